cpu_icache_lines: RTL

- Parametrised successor to the single-word direct-mapped instruction cache.
- Direct-mapped, multi-word lines, filled by a burst of single-word bus beats.
- Supports an explicit invalidate (full flush sweep).
- Sits between the fetch stage (PC / o_ready / i_stall contract unchanged) and the instruction bus arbiter.

---
 rtl/cpu_icache_pkg.sv | 34 +++
 rtl/cpu_icache_lines_if.sv | 25 ++
 rtl/cpu_icache_ram.sv | 30 +++
 rtl/cpu_icache_lines.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_icache_pkg.sv
// Shared types and sizing helpers for the multi-word-line instruction cache.
package cpu_icache_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic int unsigned log2_words(input int unsigned words);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      if ((32'd1 << i) < words) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned tag_bits(input int unsigned size, input int unsigned off);
    return 30 - size - off;
  endfunction

  // Tag entry layout: valid flag sits directly above the tag field.
  function automatic int unsigned tag_entry_bits(input int unsigned size, input int unsigned off);
    return tag_bits(size, off) + 1;
  endfunction

  function automatic int unsigned tag_valid_pos(input int unsigned size, input int unsigned off);
    return tag_bits(size, off);
  endfunction

endpackage

// File: rtl/cpu_icache_lines_if.sv
// Fetch-side and bus-side signal bundle of the instruction cache.
interface cpu_icache_lines_if;

  logic [31:0] i_input_pc;
  logic        i_stall;
  logic        i_invalidate;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_busy;
  logic        o_bus_request;
  logic        i_bus_ready;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;

  modport slave (
    input  i_input_pc, i_stall, i_invalidate, i_bus_ready, i_bus_rdata,
    output o_rdata, o_ready, o_busy, o_bus_request, o_bus_address
  );

  modport master (
    output i_input_pc, i_stall, i_invalidate, i_bus_ready, i_bus_rdata,
    input  o_rdata, o_ready, o_busy, o_bus_request, o_bus_address
  );

endinterface

// File: rtl/cpu_icache_ram.sv
// Synchronous single-port RAM with a one-cycle registered read port.
module cpu_icache_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Registered read; returns the pre-write contents on a same-address write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= {WIDTH{1'b0}};
    else         rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_icache_lines.sv
// Direct-mapped instruction cache with multi-word lines filled by in-order bus bursts.
// Optional hit/miss counters are built when CPU_ICACHE_STATS_EN is defined.
module cpu_icache_lines
  import cpu_icache_pkg::*;
#(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  cpu_icache_lines_if.slave  bus
`ifdef CPU_ICACHE_STATS_EN
  ,
  output logic [31:0]        o_hit_count,
  output logic [31:0]        o_miss_count
`endif
);

  localparam int unsigned OFF   = log2_words(LINE_WORDS);
  localparam int unsigned OFF_W = (OFF == 0) ? 1 : OFF;
  localparam int unsigned TAG_W = tag_bits(SIZE, OFF);
  localparam int unsigned TE_W  = tag_entry_bits(SIZE, OFF);
  localparam int unsigned VPOS  = tag_valid_pos(SIZE, OFF);
  localparam int unsigned DAW   = SIZE + OFF;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [SIZE:0]     cnt_q, cnt_d, cnt_inc_s;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              inv_q, inv_d;
  logic [31:0]       fetch_q, fetch_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;

  logic [31:0]       pc_s, line_base_s;
  logic [TAG_W-1:0]  tag_s;
  logic [SIZE-1:0]   index_s;
  logic [OFF_W-1:0]  word_s;
  logic              tag_match_s;
  logic              tag_we_s, data_we_s;
  logic [SIZE-1:0]   tag_addr_s;
  logic [TE_W-1:0]   tag_wdata_s, tag_rdata_s;
  logic [DAW-1:0]    data_addr_s, rd_addr_s, wr_addr_s;
  logic [31:0]       data_rdata_s;

  assign pc_s        = bus.i_input_pc;
  assign tag_s       = TAG_W'(pc_s >> (SIZE + OFF + 2));
  assign index_s     = SIZE'(pc_s >> (OFF + 2));
  assign word_s      = OFF_W'((pc_s >> 2) & (32'(LINE_WORDS) - 32'd1));
  assign line_base_s = pc_s & ~((32'(LINE_WORDS) << 2) - 32'd1);
  assign rd_addr_s   = DAW'((32'(index_s) << OFF) | 32'(word_s));
  assign wr_addr_s   = DAW'((32'(index_s) << OFF) | 32'(beat_q));
  assign cnt_inc_s   = cnt_q + {{SIZE{1'b0}}, 1'b1};
  assign tag_match_s = tag_rdata_s[VPOS] && (tag_rdata_s[TAG_W-1:0] == tag_s);

  cpu_icache_ram #(.WIDTH(TE_W), .DEPTH(32'd1 << SIZE)) u_tag_ram (
    .clk_i   (i_clock),
    .rst_ni  (i_reset),
    .we_i    (tag_we_s),
    .addr_i  (tag_addr_s),
    .wdata_i (tag_wdata_s),
    .rdata_o (tag_rdata_s)
  );

  cpu_icache_ram #(.WIDTH(32), .DEPTH(32'd1 << DAW)) u_data_ram (
    .clk_i   (i_clock),
    .rst_ni  (i_reset),
    .we_i    (data_we_s),
    .addr_i  (data_addr_s),
    .wdata_i (bus.i_bus_rdata),
    .rdata_o (data_rdata_s)
  );

  // Next-state, RAM port steering and registered-output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    inv_d       = inv_q | bus.i_invalidate;
    fetch_d     = fetch_q;
    ready_d     = 1'b0;
    rdata_d     = 32'd0;
    req_d       = req_q;
    addr_d      = addr_q;
    tag_we_s    = 1'b0;
    tag_addr_s  = index_s;
    tag_wdata_s = {TE_W{1'b0}};
    data_we_s   = 1'b0;
    data_addr_s = rd_addr_s;
    case (state_q)
      ST_INIT: begin
        tag_we_s   = 1'b1;
        tag_addr_s = cnt_q[SIZE-1:0];
        inv_d      = 1'b0;
        if (bus.i_invalidate) begin
          cnt_d = {(SIZE + 1){1'b0}};
        end else if (cnt_inc_s[SIZE]) begin
          cnt_d   = cnt_inc_s;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_IDLE: begin
        if (inv_q || bus.i_invalidate) begin
          state_d = ST_INIT;
          cnt_d   = {(SIZE + 1){1'b0}};
          inv_d   = 1'b0;
        end else if (!bus.i_stall) begin
          state_d = ST_LOOKUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (tag_match_s) begin
          ready_d = 1'b1;
          rdata_d = data_rdata_s;
          state_d = ST_IDLE;
        end else begin
          beat_d  = {OFF_W{1'b0}};
          req_d   = 1'b1;
          addr_d  = line_base_s;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        data_addr_s = wr_addr_s;
        if (bus.i_bus_ready) begin
          data_we_s = 1'b1;
          beat_d    = beat_q + OFF_W'(1'b1);
          if (beat_q == word_s) fetch_d = bus.i_bus_rdata;
          else                  fetch_d = fetch_q;
          if (beat_q == LAST_BEAT) begin
            tag_we_s    = 1'b1;
            tag_wdata_s = {1'b1, tag_s};
            req_d       = 1'b0;
            addr_d      = 32'd0;
            state_d     = ST_DONE;
          end else begin
            addr_d = line_base_s | (32'(beat_d) << 2);
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        rdata_d = fetch_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = {(SIZE + 1){1'b0}};
      end
    endcase
  end

  assign busy_d = (state_d == ST_INIT);

  // State and output registers; reset abandons any fill immediately.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= {(SIZE + 1){1'b0}};
      beat_q  <= {OFF_W{1'b0}};
      inv_q   <= 1'b0;
      fetch_q <= 32'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b1;
      req_q   <= 1'b0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      inv_q   <= inv_d;
      fetch_q <= fetch_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.o_ready       = ready_q;
  assign bus.o_rdata       = rdata_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_bus_request = req_q;
  assign bus.o_bus_address = addr_q;

`ifdef CPU_ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        lookup_hit_s, lookup_miss_s;

  assign lookup_hit_s  = (state_q == ST_LOOKUP) && tag_match_s;
  assign lookup_miss_s = (state_q == ST_LOOKUP) && !tag_match_s;

  // Saturating lookup statistics, untouched by invalidate.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (lookup_hit_s && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`endif

endmodule
